ccc_lock_supervisor: RTL and testbench

Parametrised lock supervisor and reset sequencer for a fabric clock-conditioning circuit (CCC) with up to four global outputs (GL0..GL3). It takes the CCC's asynchronous LOCK and qualifies it with a stability filter. Once lock is qualified, it releases per-channel fabric resets in a staggered order. It detects and counts lock loss, and drives the CCC's PLL_ARST_N to force a relock on loss, timeout or software request. It sits beside the CCC instance in the MSS subsystem block and feeds the fabric reset tree.

---
 rtl/ccc_lock_supervisor_if.sv | 25 ++
 rtl/ccc_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_ccc_lock_supervisor.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ccc_lock_supervisor_if.sv
// Control/status bundle between the CCC lock supervisor, the CCC instance and the fabric reset tree.
interface ccc_lock_supervisor_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              LOCK_IN;
    logic [NUM_CH-1:0] CH_EN;
    logic              FORCE_RELOCK;
    logic              PLL_ARST_N;
    logic [NUM_CH-1:0] CH_RESET_N;
    logic              LOCK_STABLE;
    logic [7:0]        LOSS_COUNT;
    logic [2:0]        STATE;

    // Supervisor side
    modport master (
        input  LOCK_IN, CH_EN, FORCE_RELOCK,
        output PLL_ARST_N, CH_RESET_N, LOCK_STABLE, LOSS_COUNT, STATE
    );

    // CCC / fabric / software side
    modport slave (
        output LOCK_IN, CH_EN, FORCE_RELOCK,
        input  PLL_ARST_N, CH_RESET_N, LOCK_STABLE, LOSS_COUNT, STATE
    );
endinterface

// File: rtl/ccc_lock_supervisor.sv
// Qualifies CCC LOCK, releases per-channel fabric resets in staggered order,
// and forces a PLL relock on lock loss, WAIT_LOCK timeout or software request.
module ccc_lock_supervisor #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned LOSS_FILTER        = 3,
    parameter int unsigned RELEASE_STAGGER    = 4,
    parameter int unsigned ARST_CYCLES        = 8,
    parameter int unsigned LOCK_TIMEOUT       = 1024,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                  CLK_BASE,
    input  logic                  RESET_N,
    ccc_lock_supervisor_if.master bus
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        LOSS      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(ARST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(NUM_CH * RELEASE_STAGGER - 1);

    state_t            state, state_n;
    logic              sync1, lock_s;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  stab_cnt, stab_n;
    logic [CNT_W-1:0]  tmo_cnt, tmo_n;
    logic [CNT_W-1:0]  lose_cnt, lose_n;
    logic [NUM_CH-1:0] ch_reset_n, ch_reset_n_n;
    logic              pll_arst_n;
    logic              lock_stable;
    logic [7:0]        loss_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        cnt_n        = sat_inc(cnt);
        stab_n       = '0;
        tmo_n        = '0;
        lose_n       = '0;
        ch_reset_n_n = '0;

        case (state)
            PLL_RST: begin
                if (cnt == ARST_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                stab_n = lock_s ? sat_inc(stab_cnt) : '0;
                tmo_n  = sat_inc(tmo_cnt);
                if (bus.FORCE_RELOCK)                      state_n = PLL_RST;
                else if (lock_s && (stab_cnt == STAB_LAST)) state_n = RELEASE;
                else if (tmo_cnt == TMO_LAST)               state_n = PLL_RST;
            end
            RELEASE, RUN: begin
                lose_n = lock_s ? '0 : sat_inc(lose_cnt);
                if (!lock_s && (lose_cnt == LOSS_LAST))        state_n = LOSS;
                else if (bus.FORCE_RELOCK)                     state_n = PLL_RST;
                else if ((state == RELEASE) && (cnt == REL_LAST)) state_n = RUN;
            end
            LOSS:    state_n = PLL_RST;
            default: state_n = PLL_RST;
        endcase

        // Every state entry starts all counters from zero
        if (state_n != state) begin
            cnt_n  = '0;
            stab_n = '0;
            tmo_n  = '0;
            lose_n = '0;
        end

        if (state_n == RUN) begin
            ch_reset_n_n = bus.CH_EN;
        end else if (state_n == RELEASE) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                ch_reset_n_n[i] = bus.CH_EN[i] && (cnt_n >= CNT_W'(i * int'(RELEASE_STAGGER)));
            end
        end
    end

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge CLK_BASE) begin
        if (!RESET_N) begin
            state       <= PLL_RST;
            sync1       <= 1'b0;
            lock_s      <= 1'b0;
            cnt         <= '0;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            lose_cnt    <= '0;
            ch_reset_n  <= '0;
            pll_arst_n  <= 1'b0;
            lock_stable <= 1'b0;
            loss_count  <= '0;
        end else begin
            state       <= state_n;
            sync1       <= bus.LOCK_IN;
            lock_s      <= sync1;
            cnt         <= cnt_n;
            stab_cnt    <= stab_n;
            tmo_cnt     <= tmo_n;
            lose_cnt    <= lose_n;
            ch_reset_n  <= ch_reset_n_n;
            pll_arst_n  <= (state_n != PLL_RST);
            lock_stable <= (state_n == RUN);
            if ((state_n == LOSS) && (state != LOSS) && (loss_count != 8'hFF)) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

    assign bus.PLL_ARST_N  = pll_arst_n;
    assign bus.CH_RESET_N  = ch_reset_n;
    assign bus.LOCK_STABLE = lock_stable;
    assign bus.LOSS_COUNT  = loss_count;
    assign bus.STATE       = state;

endmodule

// File: tb/tb_ccc_lock_supervisor.sv
// Directed bench for ccc_lock_supervisor: bring-up vector table plus hand-written
// sequences for glitch filtering, loss, timeout, forced relock, saturation and reset.
module tb_ccc_lock_supervisor;

    localparam int unsigned NUM_CH = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    ccc_lock_supervisor_if #(.NUM_CH(NUM_CH)) bus ();

    ccc_lock_supervisor #(
        .NUM_CH(NUM_CH), .LOCK_STABLE_CYCLES(16), .LOSS_FILTER(3), .RELEASE_STAGGER(4),
        .ARST_CYCLES(8), .LOCK_TIMEOUT(1024), .CNT_W(16)
    ) dut (
        .CLK_BASE(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] ch_en;
        int         at;
        logic [2:0] st;
        logic       arst;
        logic [3:0] ch;
        logic       stable;
    } vec_t;

    vec_t vecs[20];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic tick_to(input int at);
        while (cyc < at) tick(1);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic arst,
                             input logic [3:0] ch, input logic stable, input logic [7:0] loss);
        check({tag, ".state"},  16'(bus.STATE),       16'(st));
        check({tag, ".arst"},   16'(bus.PLL_ARST_N),  16'(arst));
        check({tag, ".ch"},     16'(bus.CH_RESET_N),  16'(ch));
        check({tag, ".stable"}, 16'(bus.LOCK_STABLE), 16'(stable));
        check({tag, ".loss"},   16'(bus.LOSS_COUNT),  16'(loss));
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
        int k;
        k = 0;
        while ((bus.STATE !== tgt) && (k < budget)) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (bus.STATE !== tgt) begin
            n_err++;
            $display("FAIL %s: state %0d, wanted %0d within %0d cycles", name, bus.STATE, tgt, budget);
        end
    endtask

    task automatic do_reset(input logic [3:0] ch_en, input logic lock);
        rst_n            = 1'b0;
        bus.CH_EN        = ch_en;
        bus.LOCK_IN      = lock;
        bus.FORCE_RELOCK = 1'b0;
        tick(3);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        logic [7:0] exp_loss;
        logic       saw_release;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.LOCK_IN      = 1'b0;
        bus.CH_EN        = '0;
        bus.FORCE_RELOCK = 1'b0;

        // Bring-up timeline, cycles counted from RESET_N release
        vecs[0]  = '{1'b1, 4'hF,  0, 3'd0, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'hF,  7, 3'd0, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 4'hF,  8, 3'd1, 1'b1, 4'h0, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 23, 3'd1, 1'b1, 4'h0, 1'b0};
        vecs[4]  = '{1'b0, 4'hF, 24, 3'd2, 1'b1, 4'h1, 1'b0};
        vecs[5]  = '{1'b0, 4'hF, 27, 3'd2, 1'b1, 4'h1, 1'b0};
        vecs[6]  = '{1'b0, 4'hF, 28, 3'd2, 1'b1, 4'h3, 1'b0};
        vecs[7]  = '{1'b0, 4'hF, 32, 3'd2, 1'b1, 4'h7, 1'b0};
        vecs[8]  = '{1'b0, 4'hF, 36, 3'd2, 1'b1, 4'hF, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 39, 3'd2, 1'b1, 4'hF, 1'b0};
        vecs[10] = '{1'b0, 4'hF, 40, 3'd3, 1'b1, 4'hF, 1'b1};
        vecs[11] = '{1'b1, 4'hA,  0, 3'd0, 1'b0, 4'h0, 1'b0};
        vecs[12] = '{1'b0, 4'hA,  8, 3'd1, 1'b1, 4'h0, 1'b0};
        vecs[13] = '{1'b0, 4'hA, 24, 3'd2, 1'b1, 4'h0, 1'b0};
        vecs[14] = '{1'b0, 4'hA, 27, 3'd2, 1'b1, 4'h0, 1'b0};
        vecs[15] = '{1'b0, 4'hA, 28, 3'd2, 1'b1, 4'h2, 1'b0};
        vecs[16] = '{1'b0, 4'hA, 32, 3'd2, 1'b1, 4'h2, 1'b0};
        vecs[17] = '{1'b0, 4'hA, 35, 3'd2, 1'b1, 4'h2, 1'b0};
        vecs[18] = '{1'b0, 4'hA, 36, 3'd2, 1'b1, 4'hA, 1'b0};
        vecs[19] = '{1'b0, 4'hA, 40, 3'd3, 1'b1, 4'hA, 1'b1};

        for (int v = 0; v < 20; v++) begin
            if (vecs[v].rst) do_reset(vecs[v].ch_en, 1'b1);
            tick_to(vecs[v].at);
            check_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].arst, vecs[v].ch, vecs[v].stable, 8'd0);
        end

        // RUN with CH_EN=1010: channel 1 follows CH_EN with one cycle latency
        bus.CH_EN = 4'h8;
        tick(1);
        check("ch_en_clear", 16'(bus.CH_RESET_N), 16'h8);
        bus.CH_EN = 4'hA;
        tick(1);
        check("ch_en_set", 16'(bus.CH_RESET_N), 16'hA);
        bus.CH_EN = 4'hF;
        tick(1);
        check("ch_en_all", 16'(bus.CH_RESET_N), 16'hF);

        // Two-cycle glitch is filtered
        bus.LOCK_IN = 1'b0;
        tick(2);
        bus.LOCK_IN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("glitch.state", 16'(bus.STATE), 16'd3);
        end
        check("glitch.loss", 16'(bus.LOSS_COUNT), 16'd0);

        // Three-cycle loss: LOSS five edges after LOCK_IN drops
        bus.LOCK_IN = 1'b0;
        tick(3);
        bus.LOCK_IN = 1'b1;
        tick(1);
        check("loss.pre", 16'(bus.STATE), 16'd3);
        tick(1);
        check_all("loss", 3'd4, 1'b1, 4'h0, 1'b0, 8'd1);
        tick(1);
        check_all("loss.rst0", 3'd0, 1'b0, 4'h0, 1'b0, 8'd1);
        tick(7);
        check_all("loss.rst7", 3'd0, 1'b0, 4'h0, 1'b0, 8'd1);
        tick(1);
        check_all("loss.wait", 3'd1, 1'b1, 4'h0, 1'b0, 8'd1);
        wait_state(3'd3, 100, "loss.relock");
        check_all("loss.run", 3'd3, 1'b1, 4'hF, 1'b1, 8'd1);

        // Forced relock from RUN leaves LOSS_COUNT alone
        bus.FORCE_RELOCK = 1'b1;
        tick(1);
        bus.FORCE_RELOCK = 1'b0;
        check_all("force", 3'd0, 1'b0, 4'h0, 1'b0, 8'd1);
        wait_state(3'd3, 100, "force.relock");

        // Force coincident with the filter-reaching lock-low cycle: loss wins
        bus.LOCK_IN = 1'b0;
        tick(3);
        bus.LOCK_IN = 1'b1;
        tick(1);
        bus.FORCE_RELOCK = 1'b1;
        tick(1);
        bus.FORCE_RELOCK = 1'b0;
        check_all("force_loss", 3'd4, 1'b1, 4'h0, 1'b0, 8'd2);
        tick(1);
        check("force_loss.next", 16'(bus.STATE), 16'd0);

        // No lock: WAIT_LOCK times out after 1024 cycles without counting a loss
        do_reset(4'hF, 1'b0);
        tick_to(1031);
        check_all("tmo.wait", 3'd1, 1'b1, 4'h0, 1'b0, 8'd0);
        tick_to(1032);
        check_all("tmo.rst", 3'd0, 1'b0, 4'h0, 1'b0, 8'd0);
        tick_to(1039);
        check("tmo.rst7", 16'(bus.PLL_ARST_N), 16'd0);
        tick_to(1040);
        check_all("tmo.wait2", 3'd1, 1'b1, 4'h0, 1'b0, 8'd0);

        // Lock toggling every 10 cycles never qualifies
        saw_release = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ((k % 10) == 0) bus.LOCK_IN = ~bus.LOCK_IN;
            tick(1);
            if (bus.STATE == 3'd2) saw_release = 1'b1;
        end
        check("toggle.no_release", 16'(saw_release), 16'd0);
        check("toggle.loss", 16'(bus.LOSS_COUNT), 16'd0);

        // 300 losses during RELEASE: counter saturates at 255
        do_reset(4'hF, 1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_state(3'd2, 200, "sat.release");
            bus.LOCK_IN = 1'b0;
            wait_state(3'd4, 20, "sat.loss");
            exp_loss = (i >= 254) ? 8'd255 : 8'(i + 1);
            if ((i < 3) || (i >= 252)) check("sat.count", 16'(bus.LOSS_COUNT), 16'(exp_loss));
            bus.LOCK_IN = 1'b1;
        end
        check("sat.final", 16'(bus.LOSS_COUNT), 16'd255);

        // Reset in mid-RELEASE restores all reset values on the next edge
        wait_state(3'd2, 200, "mid.release");
        tick(3);
        check("mid.pre_ch", 16'(bus.CH_RESET_N), 16'h1);
        rst_n = 1'b0;
        tick(1);
        check_all("mid.reset", 3'd0, 1'b0, 4'h0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
